// File: rtl/tt_um_rs_bin2bcd_if.sv
// Pin bundle of the Tiny Tapeout user block for the binary-to-BCD converter.
interface tt_um_rs_bin2bcd_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
  modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/tt_um_rs_bin2bcd.sv
// 8-bit binary to 3-digit BCD converter; iterative 10-cycle double-dabble by default,
// fully combinational (registered every clock) when BIN2BCD_COMB_EN is defined.
module tt_um_rs_bin2bcd (
  input logic             clk,
  input logic             rst_n,
  tt_um_rs_bin2bcd_if.slave tt
);

  function automatic logic [3:0] add3(input logic [3:0] d);
    logic [3:0] r;
    if (d >= 4'd5) begin
      r = d + 4'd3;
    end else begin
      r = d;
    end
    return r;
  endfunction

  logic [7:0] uo_q, uo_d;
  logic [1:0] hund_q, hund_d;
  logic       valid_q, valid_d;

`ifdef BIN2BCD_COMB_EN

  function automatic logic [9:0] double_dabble(input logic [7:0] b);
    logic [17:0] w;
    w = {10'd0, b};
    for (int i = 0; i < 8; i++) begin
      w[11:8]  = add3(w[11:8]);
      w[15:12] = add3(w[15:12]);
      w        = {w[16:0], 1'b0};
    end
    return w[17:8];
  endfunction

  logic [9:0] bcd_s;

  // Unrolled conversion of the live input, captured every clock
  always_comb begin
    bcd_s   = double_dabble(tt.ui_in);
    uo_d    = bcd_s[7:0];
    hund_d  = bcd_s[9:8];
    valid_d = 1'b1;
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst_n) begin
      uo_q    <= 8'd0;
      hund_q  <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      uo_q    <= uo_d;
      hund_q  <= hund_d;
      valid_q <= valid_d;
    end
  end

`else

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_UPDATE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] bin_q, bin_d;
  logic [9:0] scratch_q, scratch_d;
  logic [2:0] count_q, count_d;
  logic [9:0] adj_s;

  // Next-state and datapath: LOAD, eight SHIFT steps, then UPDATE publishes the result
  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    scratch_d = scratch_q;
    count_d   = count_q;
    uo_d      = uo_q;
    hund_d    = hund_q;
    valid_d   = 1'b0;
    // Hundreds never exceeds 2, so only tens and ones get the add-3 correction
    adj_s     = {scratch_q[9:8], add3(scratch_q[7:4]), add3(scratch_q[3:0])};
    case (state_q)
      ST_LOAD: begin
        bin_d     = tt.ui_in;
        scratch_d = 10'd0;
        count_d   = 3'd0;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        scratch_d = {adj_s[8:0], bin_q[7]};
        bin_d     = {bin_q[6:0], 1'b0};
        count_d   = count_q + 3'd1;
        if (count_q == 3'd7) begin
          state_d = ST_UPDATE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_UPDATE: begin
        uo_d    = scratch_q[7:0];
        hund_d  = scratch_q[9:8];
        valid_d = 1'b1;
        state_d = ST_LOAD;
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // State, scratch and output registers; reset aborts any conversion in flight
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q   <= ST_LOAD;
      bin_q     <= 8'd0;
      scratch_q <= 10'd0;
      count_q   <= 3'd0;
      uo_q      <= 8'd0;
      hund_q    <= 2'd0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      scratch_q <= scratch_d;
      count_q   <= count_d;
      uo_q      <= uo_d;
      hund_q    <= hund_d;
      valid_q   <= valid_d;
    end
  end

`endif

  assign tt.uo_out  = uo_q;
  assign tt.uio_out = {5'b00000, valid_q, hund_q};
  assign tt.uio_oe  = 8'b0000_0111;

  logic unused_s;
  assign unused_s = &{1'b0, tt.ena, tt.uio_in};

endmodule

// File: tb/tb_tt_um_rs_bin2bcd.sv
// Directed bench for tt_um_rs_bin2bcd with a queue of expected BCD results.
module tb_tt_um_rs_bin2bcd;

`ifdef BIN2BCD_COMB_EN
  localparam int LAT = 1;
  localparam int VW  = 1;
`else
  localparam int LAT = 10;
  localparam int VW  = 0;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  logic [9:0] exp_q[$];

  tt_um_rs_bin2bcd_if bus ();

  tt_um_rs_bin2bcd dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tt    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] model(input int v);
    logic [1:0] h;
    logic [3:0] t;
    logic [3:0] o;
    h = 2'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  task automatic check(input string tag, input int obs, input int expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic wait_result(input string tag, input int start);
    int         edges;
    logic       got;
    logic [9:0] e;
    edges = start;
    got   = 1'b0;
    while (!got && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
      if (edges == 1) check({tag, "_vwidth"}, int'(bus.uio_out[2]), VW);
      got = bus.uio_out[2];
    end
    check({tag, "_lat"}, edges, LAT);
    e = exp_q.pop_front();
    check({tag, "_tens_ones"}, int'(bus.uo_out), int'(e[7:0]));
    check({tag, "_hund"}, int'(bus.uio_out[1:0]), int'(e[9:8]));
    check({tag, "_uio_hi"}, int'(bus.uio_out[7:3]), 0);
  endtask

  task automatic run_one(input logic [7:0] v, input string tag);
    bus.ui_in = v;
    exp_q.push_back(model(int'(v)));
    wait_result(tag, 0);
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    bus.ena    = 1'b1;
    bus.uio_in = 8'd0;
    bus.ui_in  = 8'd56;
    rst_n      = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_uo_out", int'(bus.uo_out), 8'h00);
    check("rst_uio_out", int'(bus.uio_out), 8'h00);
    check("rst_uio_oe", int'(bus.uio_oe), 8'h07);

    rst_n = 1'b0;
    run_one(8'd3, "first_3");
    run_one(8'd10, "v10");
    run_one(8'd32, "v32");
    run_one(8'd56, "v56");
    run_one(8'd56, "v56_repeat");
    run_one(8'd100, "v100");
    run_one(8'd120, "v120");
    run_one(8'd0, "v0");
    run_one(8'd99, "v99");
    run_one(8'd255, "v255");

    // Abort mid-conversion: outputs must clear on the reset edge
    bus.ui_in = 8'd123;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("abort_uo_out", int'(bus.uo_out), 8'h00);
    check("abort_uio_out", int'(bus.uio_out), 8'h00);
    rst_n = 1'b0;
    run_one(8'd45, "abort_release");

`ifndef BIN2BCD_COMB_EN
    // Input changes after the LOAD edge must not affect the result
    bus.ui_in = 8'd77;
    exp_q.push_back(model(77));
    @(posedge clk);
    #1;
    bus.ui_in = 8'd200;
    @(posedge clk);
    #1;
    bus.ui_in = 8'd13;
    wait_result("toggle", 2);
`endif

    for (int i = 0; i < 256; i++) begin
      run_one(8'(i), "sweep");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
